// File: rtl/outpass4_frame_config_stretch_if.sv
// ---------------------------------------------------------------------------
// outpass4_frame_config_stretch_if
// Bundles the fabric-side inputs, the pad-side outputs and the frame
// configuration of the four-channel output-pass BEL.
//   I0..I3      fabric data, one per channel
//   CE          fabric clock enable (channels in mode 10 only)
//   O0..O3      pad-side outputs
//   ConfigBits  frame configuration, 2 bits per channel
// master : the fabric/config side (drives I, CE, ConfigBits; reads O)
// slave  : the BEL itself       (reads I, CE, ConfigBits; drives O)
// ---------------------------------------------------------------------------
interface outpass4_frame_config_stretch_if #(
   parameter int NoConfigBits = 8
);
   logic I0;
   logic I1;
   logic I2;
   logic I3;
   logic CE;
   logic O0;
   logic O1;
   logic O2;
   logic O3;
   logic [NoConfigBits-1:0] ConfigBits;

   modport master (
      output I0, I1, I2, I3, CE, ConfigBits,
      input  O0, O1, O2, O3
   );

   modport slave (
      input  I0, I1, I2, I3, CE, ConfigBits,
      output O0, O1, O2, O3
   );
endinterface

// File: rtl/outpass4_frame_config_stretch.sv
// ---------------------------------------------------------------------------
// outpass4_frame_config_stretch
// Fabric-to-pad output BEL. Each of the four channels picks its own source
// for On from a 2-bit frame-config field (channel n uses ConfigBits[2n+1:2n]):
//   00  combinational   On = In
//   01  registered      On = Qn, Qn loaded every edge
//   10  registered+CE   On = Qn, Qn loaded only when CE=1
//   11  stretcher       On = (Cn != 0), Cn reloaded on each rising edge of In
// Ports:
//   UserCLK   user clock
//   UserRSTn  asynchronous active-low reset (clears Qn, Pn, Cn)
//   bus       slave side of outpass4_frame_config_stretch_if
// All flops keep running whatever the mode, so a mode change may expose a
// stale Qn or Cn on the very next evaluation; nothing is cleared by it.
// ---------------------------------------------------------------------------
module outpass4_frame_config_stretch #(
   parameter int NoConfigBits = 8,
   parameter int STRETCH_LEN  = 4
) (
   input logic UserCLK,
   input logic UserRSTn,
   outpass4_frame_config_stretch_if.slave bus
);

   localparam int CntW = $clog2(STRETCH_LEN + 1);

   logic [NoConfigBits-1:0] cfg;
   logic [3:0]              inVec;
   logic [3:0]              qReg;
   logic [3:0]              pReg;
   logic [3:0]              outVec;
   logic [CntW-1:0]         cnt [4];

   assign cfg   = bus.ConfigBits;
   assign inVec = {bus.I3, bus.I2, bus.I1, bus.I0};

   always_ff @(posedge UserCLK or negedge UserRSTn) begin
      if (!UserRSTn) begin
         qReg <= '0;
         pReg <= '0;
         for (int n = 0; n < 4; n++) begin
            cnt[n] <= '0;
         end
      end else begin
         // Edge flop tracks In in every mode so the stretcher is armed
         // correctly the moment a channel is switched to mode 11.
         pReg <= inVec;
         for (int n = 0; n < 4; n++) begin
            if ((cfg[2*n +: 2] == 2'b01) ||
                ((cfg[2*n +: 2] == 2'b10) && bus.CE)) begin
               qReg[n] <= inVec[n];
            end
            // A rise reloads the counter even mid-pulse (retrigger);
            // otherwise a running count decays towards zero.
            if (inVec[n] && !pReg[n]) begin
               cnt[n] <= CntW'(STRETCH_LEN);
            end else if (cnt[n] != '0) begin
               cnt[n] <= cnt[n] - CntW'(1);
            end
         end
      end
   end

   always_comb begin
      outVec = '0;
      for (int n = 0; n < 4; n++) begin
         case (cfg[2*n +: 2])
            2'b00:        outVec[n] = inVec[n];
            2'b01, 2'b10: outVec[n] = qReg[n];
            default:      outVec[n] = (cnt[n] != '0);
         endcase
      end
   end

   assign bus.O0 = outVec[0];
   assign bus.O1 = outVec[1];
   assign bus.O2 = outVec[2];
   assign bus.O3 = outVec[3];

endmodule

// File: tb/tb_outpass4_frame_config_stretch.sv
// ---------------------------------------------------------------------------
// Bench for outpass4_frame_config_stretch: reset checks, a vector table,
// hand-written stretcher sequences, then random traffic against a
// timestamp-based reference model.
// ---------------------------------------------------------------------------
module tb_outpass4_frame_config_stretch;

   localparam int STRETCH_LEN = 4;

   logic UserCLK;
   logic UserRSTn;

   outpass4_frame_config_stretch_if #(.NoConfigBits(8)) bus ();

   outpass4_frame_config_stretch #(
      .NoConfigBits(8),
      .STRETCH_LEN (STRETCH_LEN)
   ) dut (
      .UserCLK (UserCLK),
      .UserRSTn(UserRSTn),
      .bus     (bus)
   );

   // ---------------- clock ----------------
   initial UserCLK = 1'b0;
   always #5 UserCLK = ~UserCLK;

   // ---------------- check bookkeeping ----------------
   int passCount  = 0;
   int totalCount = 0;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      totalCount++;
      if (act === exp) passCount++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask

   // ---------------- driver helpers ----------------
   task automatic setIn(input logic [3:0] v);
      bus.I0 = v[0];
      bus.I1 = v[1];
      bus.I2 = v[2];
      bus.I3 = v[3];
   endtask

   function automatic logic [3:0] getOut();
      return {bus.O3, bus.O2, bus.O1, bus.O0};
   endfunction

   // Ends at posedge+1 with reset released and all flops cleared.
   task automatic applyReset();
      UserRSTn = 1'b0;
      @(posedge UserCLK);
      @(posedge UserCLK);
      #1;
      UserRSTn = 1'b1;
   endtask

   // ---------------- reference model ----------------
   // Stretcher modelled by the edge index of the last rise: On is high
   // while fewer than STRETCH_LEN edges have passed since that rise.
   logic [3:0] mq;
   logic [3:0] mPrev;
   int         mLast [4];
   int         mEdge;

   task automatic modelReset();
      mq    = '0;
      mPrev = '0;
      for (int n = 0; n < 4; n++) mLast[n] = -1000;
   endtask

   task automatic modelEdge(input logic [7:0] c, input logic [3:0] iv, input logic ce);
      mEdge++;
      for (int n = 0; n < 4; n++) begin
         if (c[2*n +: 2] == 2'd1 || (c[2*n +: 2] == 2'd2 && ce)) mq[n] = iv[n];
         if (iv[n] && !mPrev[n]) mLast[n] = mEdge;
      end
      mPrev = iv;
   endtask

   function automatic logic [3:0] modelOut(input logic [7:0] c, input logic [3:0] iv);
      logic [3:0] r;
      r = '0;
      for (int n = 0; n < 4; n++) begin
         case (c[2*n +: 2])
            2'd0:    r[n] = iv[n];
            2'd1,
            2'd2:    r[n] = mq[n];
            default: r[n] = ((mEdge - mLast[n]) < STRETCH_LEN);
         endcase
      end
      return r;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0] iv;
      logic       ce;
      logic       clk;
      logic [3:0] expO;
   } vec_t;

   vec_t tbl [17];

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] rcfg;
      logic [3:0] iv;
      logic       ce;
      logic [6:0] bExp;
      int         highs;
      int         rises;
      logic       lastO3;
      logic       sawHigh;

      // ch3 mode 11, ch2 mode 10, ch1 mode 01, ch0 mode 00
      tbl[0]  = '{4'b0001, 1'b0, 1'b0, 4'b0001};
      tbl[1]  = '{4'b0000, 1'b0, 1'b0, 4'b0000};
      tbl[2]  = '{4'b0010, 1'b0, 1'b0, 4'b0000};
      tbl[3]  = '{4'b0010, 1'b0, 1'b1, 4'b0010};
      tbl[4]  = '{4'b0100, 1'b0, 1'b1, 4'b0000};
      tbl[5]  = '{4'b0100, 1'b0, 1'b1, 4'b0000};
      tbl[6]  = '{4'b0100, 1'b0, 1'b1, 4'b0000};
      tbl[7]  = '{4'b0100, 1'b1, 1'b1, 4'b0100};
      tbl[8]  = '{4'b0000, 1'b0, 1'b1, 4'b0100};
      tbl[9]  = '{4'b1000, 1'b0, 1'b0, 4'b0100};
      tbl[10] = '{4'b1000, 1'b0, 1'b1, 4'b1100};
      tbl[11] = '{4'b0000, 1'b0, 1'b1, 4'b1100};
      tbl[12] = '{4'b0000, 1'b0, 1'b1, 4'b1100};
      tbl[13] = '{4'b0000, 1'b0, 1'b1, 4'b1100};
      tbl[14] = '{4'b0000, 1'b0, 1'b1, 4'b0100};
      tbl[15] = '{4'b0001, 1'b1, 1'b0, 4'b0101};
      tbl[16] = '{4'b0001, 1'b1, 1'b1, 4'b0001};

      mEdge = 0;
      modelReset();

      // Reset state, and mode 00 following In while reset is held.
      UserRSTn = 1'b0;
      bus.CE = 1'b0;
      bus.ConfigBits = 8'b11_10_01_00;
      setIn(4'b0000);
      #1;
      check("reset_outputs", getOut(), 4'b0000);
      setIn(4'b0011);
      #1;
      check("reset_mode00_follows", getOut(), 4'b0001);
      @(posedge UserCLK);
      #1;
      check("reset_held_over_edge", getOut(), 4'b0001);
      setIn(4'b0000);
      applyReset();

      // Table: each entry either settles without a clock edge or takes one.
      for (int i = 0; i < 17; i++) begin
         setIn(tbl[i].iv);
         bus.CE = tbl[i].ce;
         if (tbl[i].clk) begin
            @(posedge UserCLK);
            #1;
         end else begin
            #2;
         end
         check($sformatf("table_%0d", i), getOut(), tbl[i].expO);
      end

      // Mode 01: asynchronous reset drops O1 immediately.
      bus.ConfigBits = 8'b00_00_01_00;
      setIn(4'b0010);
      @(posedge UserCLK);
      #1;
      check("m01_loaded", getOut(), 4'b0010);
      #2;
      UserRSTn = 1'b0;
      #1;
      check("m01_async_reset", getOut(), 4'b0000);
      setIn(4'b0000);
      applyReset();

      // Mode 11 retrigger: rises sampled at edges 0 and 2 keep O3 high
      // through edge 5, low at edge 6.
      bus.ConfigBits = 8'hFF;
      bExp = 7'b0111111;
      for (int j = 0; j < 7; j++) begin
         setIn({(j == 0 || j == 2), 3'b000});
         @(posedge UserCLK);
         #1;
         check($sformatf("retrigger_edge%0d", j), {3'b000, bus.O3}, {3'b000, bExp[j]});
      end

      // Mode 11 with I3 held high for 10 edges: a single 4-cycle pulse.
      highs  = 0;
      rises  = 0;
      lastO3 = bus.O3;
      for (int j = 0; j < 14; j++) begin
         setIn({(j < 10), 3'b000});
         @(posedge UserCLK);
         #1;
         if (bus.O3) highs++;
         if (bus.O3 && !lastO3) rises++;
         lastO3 = bus.O3;
      end
      check("held_high_len", 4'(highs), 4'(STRETCH_LEN));
      check("held_high_pulses", 4'(rises), 4'd1);

      // Reset in the middle of a stretch.
      setIn(4'b1000);
      @(posedge UserCLK);
      #1;
      setIn(4'b0000);
      @(posedge UserCLK);
      #1;
      check("mid_stretch_high", {3'b000, bus.O3}, 4'b0001);
      UserRSTn = 1'b0;
      #1;
      check("mid_stretch_reset", {3'b000, bus.O3}, 4'b0000);
      @(posedge UserCLK);
      #1;
      UserRSTn = 1'b1;
      sawHigh = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(posedge UserCLK);
         #1;
         if (bus.O3) sawHigh = 1'b1;
      end
      check("after_reset_cnt_clear", {3'b000, sawHigh}, 4'b0000);

      // In already high across reset release is a rise at the first edge.
      UserRSTn = 1'b0;
      setIn(4'b1000);
      #2;
      UserRSTn = 1'b1;
      #1;
      check("release_before_edge", {3'b000, bus.O3}, 4'b0000);
      @(posedge UserCLK);
      #1;
      check("release_first_edge_rise", {3'b000, bus.O3}, 4'b0001);

      // Random traffic against the reference model.
      setIn(4'b0000);
      applyReset();
      modelReset();
      rcfg = 8'($urandom_range(0, 255));
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if ($urandom_range(0, 49) == 0) rcfg = 8'($urandom_range(0, 255));
         iv = 4'($urandom_range(0, 15));
         ce = 1'($urandom_range(0, 1));
         UserRSTn = ($urandom_range(0, 199) != 0);
         bus.ConfigBits = rcfg;
         bus.CE = ce;
         setIn(iv);
         if (!UserRSTn) modelReset();
         #1;
         check($sformatf("rand_comb_%0d", cyc), getOut(), modelOut(rcfg, iv));
         @(posedge UserCLK);
         if (UserRSTn) modelEdge(rcfg, iv, ce);
         #1;
         check($sformatf("rand_edge_%0d", cyc), getOut(), modelOut(rcfg, iv));
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
